l2_tcdm_bank_arbiter: RTL

Sits between the TCDM/lint masters and one single-port L2 SRAM bank. Sources are the JTAG lint master and the priority (core/DMA) master. Each cycle it grants at most one request using 2-way round-robin, and drives the SRAM macro pins directly. It returns read data and the response valid on the next cycle, routed to the master that was granted.

---
 rtl/l2_tcdm_pkg.sv | 18 +
 rtl/rr_arb_2.sv | 33 +++
 rtl/l2_tcdm_bank_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/l2_tcdm_pkg.sv
// Shared types and constants for the L2 TCDM bank arbiter.
package l2_tcdm_pkg;

    localparam int DW = 32;

    localparam logic        OPC_OK    = 1'b0;
    localparam logic        OPC_ERR   = 1'b1;
    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    // One TCDM request as seen by the bank
    typedef struct packed {
        logic [31:0]     add;
        logic            wen;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] be;
    } tcdm_req_t;

endpackage

// File: rtl/rr_arb_2.sv
// Two-way round-robin arbiter; rr_q remembers the last conflict winner.
module rr_arb_2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic rr_q;
    logic rr_d;

    // Sole requester always wins; on conflict the one not granted last wins
    always_comb begin
        gnt_o = 2'b00;
        rr_d  = rr_q;
        case (req_i)
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: begin
                gnt_o = rr_q ? 2'b01 : 2'b10;
                rr_d  = ~rr_q;
            end
            default: gnt_o = 2'b00;
        endcase
    end

    // Pointer resets to 1 so master 0 wins the first conflict
    always_ff @(posedge clk_i) begin
        if (rst_i) rr_q <= 1'b1;
        else       rr_q <= rr_d;
    end

endmodule

// File: rtl/l2_tcdm_bank_arbiter.sv
// Arbitrates the JTAG lint master (m0) and the priority master (m1) onto one
// single-port L2 SRAM bank; responses come back one cycle after the grant.
// Optional macro L2_ADDR_CHECK_EN: out-of-bank addresses are granted but not
// sent to the SRAM, and answer with an error response instead.
module l2_tcdm_bank_arbiter #(
    parameter int          MEM_AW    = 6,
    parameter int          DW        = 32,
    parameter logic [31:0] BASE_ADDR = 32'h1C00_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic [31:0]       m0_add_i,
    input  logic              m0_wen_i,
    input  logic [DW-1:0]     m0_wdata_i,
    input  logic [DW/8-1:0]   m0_be_i,
    output logic              m0_gnt_o,
    output logic              m0_r_valid_o,
    output logic [DW-1:0]     m0_r_rdata_o,
    output logic              m0_r_opc_o,
    input  logic              m1_req_i,
    input  logic [31:0]       m1_add_i,
    input  logic              m1_wen_i,
    input  logic [DW-1:0]     m1_wdata_i,
    input  logic [DW/8-1:0]   m1_be_i,
    output logic              m1_gnt_o,
    output logic              m1_r_valid_o,
    output logic [DW-1:0]     m1_r_rdata_o,
    output logic              m1_r_opc_o,
    output logic              mem_csn_o,
    output logic              mem_wen_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    output logic [DW/8-1:0]   mem_be_o,
    input  logic [DW-1:0]     mem_rdata_i
);

    import l2_tcdm_pkg::*;

    logic [1:0] req;
    logic [1:0] gnt;
    tcdm_req_t  sel;
    logic       in_range;
    logic       hit;

    logic       resp_vld_q, resp_vld_d;
    logic       resp_id_q,  resp_id_d;
    logic       resp_rd_q,  resp_rd_d;
    logic       resp_err_q, resp_err_d;

    logic          rsp_vld;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_opc;
    logic          unused_addr_bits;

    // No new access is granted while reset is held
    assign req = {m1_req_i, m0_req_i} & {2{~rst_i}};

    rr_arb_2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];

    // Select the granted master's request
    always_comb begin
        if (gnt[1]) sel = '{add: m1_add_i, wen: m1_wen_i, wdata: m1_wdata_i, be: m1_be_i};
        else        sel = '{add: m0_add_i, wen: m0_wen_i, wdata: m0_wdata_i, be: m0_be_i};
    end

`ifdef L2_ADDR_CHECK_EN
    localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + (33'd4 << MEM_AW);
    assign in_range = ({1'b0, sel.add} >= {1'b0, BASE_ADDR}) && ({1'b0, sel.add} < ADDR_END);
`else
    assign in_range = 1'b1;
`endif

    assign hit = (|gnt) & in_range;
    // Byte-offset bits never matter; upper bits only matter with the range check
    assign unused_addr_bits = ^{sel.add[31:MEM_AW+2], sel.add[1:0]};

    // SRAM pins: idle values unless an in-range access is granted
    always_comb begin
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (hit) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = sel.wen;
            mem_addr_o  = sel.add[MEM_AW+1:2];
            mem_wdata_o = sel.wdata;
            mem_be_o    = sel.be;
        end
    end

    // Next-state of the response tracker
    always_comb begin
        resp_vld_d = |gnt;
        resp_id_d  = gnt[1];
        resp_rd_d  = sel.wen;
        resp_err_d = (|gnt) & ~in_range;
    end

    // Response tracker; reset drops any pending response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_vld_q <= 1'b0;
            resp_id_q  <= 1'b0;
            resp_rd_q  <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            resp_vld_q <= resp_vld_d;
            resp_id_q  <= resp_id_d;
            resp_rd_q  <= resp_rd_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign rsp_vld = resp_vld_q & ~rst_i;

`ifdef L2_ADDR_CHECK_EN
    assign rsp_rdata = resp_err_q ? ERR_RDATA : (resp_rd_q ? mem_rdata_i : '0);
    assign rsp_opc   = resp_err_q ? OPC_ERR : OPC_OK;
`else
    assign rsp_rdata = resp_rd_q ? mem_rdata_i : '0;
    assign rsp_opc   = OPC_OK;
`endif

    // Route the response to the master that owns it; the other sees zeros
    always_comb begin
        m0_r_valid_o = rsp_vld & ~resp_id_q;
        m1_r_valid_o = rsp_vld &  resp_id_q;
        m0_r_rdata_o = m0_r_valid_o ? rsp_rdata : '0;
        m1_r_rdata_o = m1_r_valid_o ? rsp_rdata : '0;
        m0_r_opc_o   = m0_r_valid_o & rsp_opc;
        m1_r_opc_o   = m1_r_valid_o & rsp_opc;
    end

endmodule
